// File: rtl/seg_scan_decoder_if.sv
// Bundle of the 7-segment scan lines and the decoded-frame results seen by
// the scan receiver.
interface seg_scan_decoder_if;
    logic [7:0]  seg;
    logic [3:0]  an;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic [3:0]  blank;
    logic        frame_valid;
    logic        frame_bad;
    logic        scan_err;
    logic        stale;

    modport master (
        output seg, an,
        input  digits, dp, blank, frame_valid, frame_bad, scan_err, stale
    );

    modport slave (
        input  seg, an,
        output digits, dp, blank, frame_valid, frame_bad, scan_err, stale
    );
endinterface

// File: rtl/seg_scan_decoder.sv
// Multiplexed 7-segment scan receiver: waits for each anode dwell to settle,
// decodes the lit digit back to a nibble and republishes complete 4-digit frames.
module seg_scan_decoder #(
    parameter int SETTLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              Clk100Mhz,
    input  logic              Rst_n,
    seg_scan_decoder_if.slave bus
);
    localparam int CW = $clog2(SETTLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] SETTLE_MAX  = CW'(SETTLE_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_MAX = TW'(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TIMEOUT_PRE = TW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {WAIT = 2'd0, SETTLING = 2'd1, DONE = 2'd2} dwell_e;

    // Returns {recognised, blank, nibble} for an active-low g..a pattern.
    function automatic logic [5:0] decodeSeg(input logic [6:0] pat);
        logic [5:0] r;
        case (pat)
            7'b1000000: r = 6'b10_0000;
            7'b1111001: r = 6'b10_0001;
            7'b0100100: r = 6'b10_0010;
            7'b0110000: r = 6'b10_0011;
            7'b0011001: r = 6'b10_0100;
            7'b0010010: r = 6'b10_0101;
            7'b0000010: r = 6'b10_0110;
            7'b1111000: r = 6'b10_0111;
            7'b0000000: r = 6'b10_1000;
            7'b0010000: r = 6'b10_1001;
            7'b0001000: r = 6'b10_1010;
            7'b0000011: r = 6'b10_1011;
            7'b1000110: r = 6'b10_1100;
            7'b0100001: r = 6'b10_1101;
            7'b0000110: r = 6'b10_1110;
            7'b0001110: r = 6'b10_1111;
            7'b1111111: r = 6'b11_0000;
            default:    r = 6'b00_0000;
        endcase
        return r;
    endfunction

    function automatic logic [2:0] lowCount(input logic [3:0] a);
        logic [2:0] n;
        n = 3'd0;
        for (int i = 0; i < 4; i++) n = n + {2'b00, ~a[i]};
        return n;
    endfunction

    logic [11:0]     curVal_s, prev_r;
    logic            change_s, settleHit_s, capture_s, scanErrHit_s;
    logic            frameDone_s, timeoutHit_s;
    logic [CW-1:0]   stableCnt_r;
    logic [TW-1:0]   toCnt_r;
    dwell_e          dwellState_r, dwellNext_s;
    logic [2:0]      lows_s;
    logic [1:0]      capIdx_s;
    logic [5:0]      decoded_s;
    logic [3:0]      seen_r, seenNext_s, dpSh_r, dpShNext_s, blankSh_r, blankShNext_s;
    logic [3:0][3:0] shadow_r, shadowNext_s;
    logic            frameBadSh_r, frameBadShNext_s;
    logic [15:0]     digits_r;
    logic [3:0]      dp_r, blank_r;
    logic            frameValid_r, frameBad_r, scanErr_r, stale_r;

    assign curVal_s     = {bus.an, bus.seg};
    assign change_s     = (curVal_s != prev_r);
    assign lows_s       = lowCount(prev_r[11:8]);
    assign decoded_s    = decodeSeg(prev_r[6:0]);
    assign capture_s    = settleHit_s && (lows_s == 3'd1);
    assign scanErrHit_s = settleHit_s && (lows_s > 3'd1);
    assign frameDone_s  = (seen_r == 4'hF);
    // A capture in the same cycle as the timeout point takes priority.
    assign timeoutHit_s = !capture_s && (toCnt_r == TIMEOUT_PRE);

    // Input sample register and saturating stability counter.
    always_ff @(posedge Clk100Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            prev_r       <= 12'hFFF;
            stableCnt_r  <= '0;
            dwellState_r <= WAIT;
        end else begin
            prev_r       <= curVal_s;
            dwellState_r <= dwellNext_s;
            if (change_s) begin
                stableCnt_r <= '0;
            end else if (stableCnt_r != SETTLE_MAX) begin
                stableCnt_r <= stableCnt_r + CW'(1);
            end else begin
                stableCnt_r <= stableCnt_r;
            end
        end
    end

    // Dwell FSM: fires settleHit_s exactly once per stable dwell.
    always_comb begin
        dwellNext_s = dwellState_r;
        settleHit_s = 1'b0;
        if (change_s) begin
            dwellNext_s = WAIT;
        end else begin
            case (dwellState_r)
                WAIT, SETTLING: begin
                    if (stableCnt_r == SETTLE_MAX) begin
                        settleHit_s = 1'b1;
                        dwellNext_s = DONE;
                    end else begin
                        dwellNext_s = SETTLING;
                    end
                end
                DONE:    dwellNext_s = DONE;
                default: dwellNext_s = WAIT;
            endcase
        end
    end

    // Selected digit index and next-state of the partial-frame shadows.
    always_comb begin
        case (prev_r[11:8])
            4'b1110: capIdx_s = 2'd0;
            4'b1101: capIdx_s = 2'd1;
            4'b1011: capIdx_s = 2'd2;
            4'b0111: capIdx_s = 2'd3;
            default: capIdx_s = 2'd0;
        endcase
        shadowNext_s  = shadow_r;
        dpShNext_s    = dpSh_r;
        blankShNext_s = blankSh_r;
        if (frameDone_s || timeoutHit_s) begin
            seenNext_s       = 4'h0;
            frameBadShNext_s = 1'b0;
        end else begin
            seenNext_s       = seen_r;
            frameBadShNext_s = frameBadSh_r;
        end
        if (capture_s) begin
            seenNext_s[capIdx_s]    = 1'b1;
            shadowNext_s[capIdx_s]  = decoded_s[3:0];
            dpShNext_s[capIdx_s]    = ~prev_r[7];
            blankShNext_s[capIdx_s] = decoded_s[4];
            frameBadShNext_s        = frameBadShNext_s | ~decoded_s[5];
        end else begin
            shadowNext_s = shadow_r;
        end
    end

    // Partial-frame shadows and the no-capture timeout counter.
    always_ff @(posedge Clk100Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            seen_r       <= 4'h0;
            shadow_r     <= '0;
            dpSh_r       <= 4'h0;
            blankSh_r    <= 4'h0;
            frameBadSh_r <= 1'b0;
            toCnt_r      <= '0;
        end else begin
            seen_r       <= seenNext_s;
            shadow_r     <= shadowNext_s;
            dpSh_r       <= dpShNext_s;
            blankSh_r    <= blankShNext_s;
            frameBadSh_r <= frameBadShNext_s;
            if (capture_s) begin
                toCnt_r <= '0;
            end else if (toCnt_r != TIMEOUT_MAX) begin
                toCnt_r <= toCnt_r + TW'(1);
            end else begin
                toCnt_r <= toCnt_r;
            end
        end
    end

    // Published frame and status pulses.
    always_ff @(posedge Clk100Mhz or negedge Rst_n) begin
        if (!Rst_n) begin
            digits_r     <= 16'h0000;
            dp_r         <= 4'h0;
            blank_r      <= 4'hF;
            frameValid_r <= 1'b0;
            frameBad_r   <= 1'b0;
            scanErr_r    <= 1'b0;
            stale_r      <= 1'b0;
        end else begin
            frameValid_r <= frameDone_s;
            scanErr_r    <= scanErrHit_s;
            if (frameDone_s) begin
                digits_r   <= shadow_r;
                dp_r       <= dpSh_r;
                blank_r    <= blankSh_r;
                frameBad_r <= frameBadSh_r;
                stale_r    <= 1'b0;
            end else if (timeoutHit_s) begin
                stale_r <= 1'b1;
            end else begin
                stale_r <= stale_r;
            end
        end
    end

    assign bus.digits      = digits_r;
    assign bus.dp          = dp_r;
    assign bus.blank       = blank_r;
    assign bus.frame_valid = frameValid_r;
    assign bus.frame_bad   = frameBad_r;
    assign bus.scan_err    = scanErr_r;
    assign bus.stale       = stale_r;
endmodule

// File: tb/tb_seg_scan_decoder.sv
// Bench for seg_scan_decoder: directed scans plus random dwells, every cycle
// compared against a dwell-length based reference model.
module tb_seg_scan_decoder;
    localparam int S = 4;
    localparam int T = 50;
    localparam logic [6:0] SEG_TAB [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    logic clk = 1'b0;
    logic rstN = 1'b0;
    always #5 clk = ~clk;

    seg_scan_decoder_if ssIf ();
    seg_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .Clk100Mhz(clk),
        .Rst_n    (rstN),
        .bus      (ssIf.slave)
    );

    int vectors = 0;
    int miscompares = 0;
    int cycle = 0;
    int fvCount = 0;
    int errCount = 0;
    logic [15:0] lastDigits = 16'h0;
    logic [3:0]  lastDp = 4'h0, lastBlank = 4'h0;
    logic        lastBad = 1'b0;

    // reference model state: current dwell and how long it has lasted
    logic [11:0]     mLast;
    int              mRun, mNoCap;
    logic [3:0]      mSeen, mDpSh, mBlSh;
    logic [3:0][3:0] mSh;
    logic            mBadSh;
    logic [15:0]     eDigits;
    logic [3:0]      eDp, eBlank;
    logic            eFv, eBad, eErr, eStale;

    function automatic logic [5:0] refDecode(input logic [6:0] p);
        if (p == 7'h7F) return 6'b110000;
        for (int i = 0; i < 16; i++) if (SEG_TAB[i] == p) return {2'b10, 4'(i)};
        return 6'b000000;
    endfunction

    function automatic logic [3:0] anOf(input int i);
        logic [3:0] r;
        r = 4'b0001 << i;
        return ~r;
    endfunction

    task automatic modelReset();
        mLast = 12'hFFF; mRun = 1; mNoCap = 0;
        mSeen = 4'h0; mDpSh = 4'h0; mBlSh = 4'h0; mSh = '0; mBadSh = 1'b0;
        eDigits = 16'h0; eDp = 4'h0; eBlank = 4'hF;
        eFv = 1'b0; eBad = 1'b0; eErr = 1'b0; eStale = 1'b0;
    endtask

    // Advance the model by one clock with the inputs present during this cycle.
    task automatic modelStep(input logic [3:0] a, input logic [7:0] s);
        int lows, idx;
        logic fire, cap, done, tmo;
        logic [5:0] d;
        if ({a, s} == mLast) begin
            if (mRun < 1000) mRun++;
        end else begin
            mLast = {a, s};
            mRun = 1;
        end
        fire = (mRun == S + 2);
        lows = 0; idx = 0;
        for (int i = 0; i < 4; i++) if (!a[i]) begin lows++; idx = i; end
        cap = fire && (lows == 1);
        eErr = fire && (lows >= 2);
        done = (mSeen == 4'hF);
        tmo = 1'b0;
        if (cap) mNoCap = 0;
        else if (mNoCap < T) begin mNoCap++; tmo = (mNoCap == T); end
        eFv = done;
        if (done) begin
            eDigits = mSh; eDp = mDpSh; eBlank = mBlSh; eBad = mBadSh; eStale = 1'b0;
        end else if (tmo) eStale = 1'b1;
        if (done || tmo) begin mSeen = 4'h0; mBadSh = 1'b0; end
        if (cap) begin
            d = refDecode(s[6:0]);
            mSh[idx] = d[3:0]; mDpSh[idx] = ~s[7]; mBlSh[idx] = d[4];
            mBadSh = mBadSh | ~d[5]; mSeen[idx] = 1'b1;
        end
    endtask

    // Called on each falling edge: compare outputs, then advance the model.
    task automatic cycleCheck();
        logic [27:0] act, exp;
        cycle++;
        if (!rstN) modelReset();
        act = {ssIf.digits, ssIf.dp, ssIf.blank, ssIf.frame_valid, ssIf.frame_bad, ssIf.scan_err, ssIf.stale};
        exp = {eDigits, eDp, eBlank, eFv, eBad, eErr, eStale};
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL cycle %0d outputs: got %h expected %h", cycle, act, exp);
        end
        if (ssIf.frame_valid) begin
            fvCount++;
            lastDigits = ssIf.digits; lastDp = ssIf.dp; lastBlank = ssIf.blank; lastBad = ssIf.frame_bad;
        end
        if (ssIf.scan_err) errCount++;
        if (rstN) modelStep(ssIf.an, ssIf.seg);
    endtask

    task automatic drive(input logic [3:0] a, input logic [7:0] s, input int n);
        ssIf.an = a; ssIf.seg = s;
        repeat (n) begin
            @(negedge clk); cycleCheck();
            @(posedge clk); #1;
        end
    endtask

    task automatic scan4(input logic [15:0] val, input int dwell);
        for (int i = 0; i < 4; i++) drive(anOf(i), {1'b1, SEG_TAB[val[4*i +: 4]]}, dwell);
    endtask

    task automatic checkLit(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    int fvBefore, errBefore;
    logic [3:0] ra;
    logic [6:0] rs;
    int rn;

    initial begin
        ssIf.an = 4'hF; ssIf.seg = 8'hFF;
        modelReset();
        repeat (4) begin @(negedge clk); cycleCheck(); end
        @(posedge clk); #1 rstN = 1'b1;
        checkLit("reset digits", 32'(ssIf.digits), 32'h0);
        checkLit("reset blank", 32'(ssIf.blank), 32'hF);
        checkLit("reset stale", 32'(ssIf.stale), 32'h0);

        // basic frame 4321
        fvBefore = fvCount;
        scan4(16'h4321, 16);
        drive(4'hF, 8'hFF, 6);
        checkLit("basic fv count", 32'(fvCount - fvBefore), 32'd1);
        checkLit("basic digits", 32'(lastDigits), 32'h4321);
        checkLit("basic dp", 32'(lastDp), 32'h0);
        checkLit("basic blank", 32'(lastBlank), 32'h0);
        checkLit("basic bad", 32'(lastBad), 32'h0);

        // short anode overlaps are filtered, a held overlap is flagged once
        fvBefore = fvCount; errBefore = errCount;
        for (int i = 0; i < 4; i++) begin
            drive(anOf(i), {1'b1, SEG_TAB[i + 1]}, 16);
            if (i < 3) drive(4'b1100, {1'b1, SEG_TAB[i + 2]}, 2);
        end
        drive(4'hF, 8'hFF, 6);
        checkLit("overlap err", 32'(errCount - errBefore), 32'd0);
        checkLit("overlap fv count", 32'(fvCount - fvBefore), 32'd1);
        checkLit("overlap digits", 32'(lastDigits), 32'h4321);
        drive(4'b1100, 8'hF9, 8);
        drive(4'hF, 8'hFF, 4);
        checkLit("held overlap err", 32'(errCount - errBefore), 32'd1);

        // blank digit with its decimal point lit
        drive(anOf(0), 8'hC0, 16);
        drive(anOf(1), 8'hC0, 16);
        drive(anOf(2), 8'h7F, 16);
        drive(anOf(3), 8'hC0, 16);
        drive(4'hF, 8'hFF, 6);
        checkLit("blank digits", 32'(lastDigits), 32'h0);
        checkLit("blank mask", 32'(lastBlank), 32'h4);
        checkLit("blank dp", 32'(lastDp), 32'h4);

        // unrecognised pattern flags the frame, next clean frame clears it
        drive(anOf(0), {1'b1, SEG_TAB[5]}, 16);
        drive(anOf(1), 8'hD5, 16);
        drive(anOf(2), {1'b1, SEG_TAB[7]}, 16);
        drive(anOf(3), {1'b1, SEG_TAB[8]}, 16);
        drive(4'hF, 8'hFF, 6);
        checkLit("bad digits", 32'(lastDigits), 32'h8705);
        checkLit("bad flag", 32'(lastBad), 32'h1);
        scan4(16'h4321, 16);
        drive(4'hF, 8'hFF, 6);
        checkLit("bad cleared", 32'(lastBad), 32'h0);

        // partial frame then silence -> stale, outputs held
        fvBefore = fvCount;
        drive(anOf(0), {1'b1, SEG_TAB[1]}, 16);
        drive(anOf(1), {1'b1, SEG_TAB[2]}, 16);
        drive(4'hF, 8'hFF, 60);
        checkLit("stale set", 32'(ssIf.stale), 32'h1);
        checkLit("stale no fv", 32'(fvCount - fvBefore), 32'd0);
        checkLit("stale held digits", 32'(ssIf.digits), 32'h4321);
        scan4(16'hBA98, 16);
        drive(4'hF, 8'hFF, 4);
        checkLit("stale recover digits", 32'(lastDigits), 32'hBA98);
        checkLit("stale cleared", 32'(ssIf.stale), 32'h0);

        // reset mid-frame discards the partial shadows
        fvBefore = fvCount;
        drive(anOf(0), {1'b1, SEG_TAB[1]}, 16);
        drive(anOf(1), {1'b1, SEG_TAB[2]}, 16);
        drive(anOf(2), {1'b1, SEG_TAB[3]}, 10);
        rstN = 1'b0;
        drive(anOf(2), {1'b1, SEG_TAB[3]}, 3);
        rstN = 1'b1;
        drive(anOf(2), {1'b1, SEG_TAB[3]}, 4);
        drive(anOf(3), {1'b1, SEG_TAB[4]}, 16);
        drive(4'hF, 8'hFF, 5);
        checkLit("rst no fv", 32'(fvCount - fvBefore), 32'd0);
        checkLit("rst digits", 32'(ssIf.digits), 32'h0);
        checkLit("rst blank", 32'(ssIf.blank), 32'hF);
        checkLit("rst dp", 32'(ssIf.dp), 32'h0);
        checkLit("rst bad", 32'(ssIf.frame_bad), 32'h0);

        // random dwells against the model
        for (int k = 0; k < 400; k++) begin
            case ($urandom_range(0, 9))
                0:       ra = 4'hF;
                1:       ra = 4'($urandom);
                default: ra = anOf(int'($urandom_range(0, 3)));
            endcase
            case ($urandom_range(0, 9))
                0:       rs = 7'h7F;
                1:       rs = 7'($urandom);
                default: rs = SEG_TAB[4'($urandom_range(0, 15))];
            endcase
            rn = int'($urandom_range(1, 12));
            if ($urandom_range(0, 30) == 0) rn = 60;
            drive(ra, {1'($urandom_range(0, 1)), rs}, rn);
        end
        drive(4'hF, 8'hFF, 8);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
